// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU report illegal_op.
module mdu_hilo #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            busy,
  output logic            done,
  output logic            illegal_op,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

  logic [1:0]        state;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic              neg_q;

  logic              is_signed, rs_neg, rt_neg, op_mul, op_div;
  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_next, prod;
  logic [XLEN-1:0]   res_hi, res_lo;

`ifdef MDU_DIV_EN
  logic              is_div, dz, neg_r;
  logic [XLEN:0]     div_diff;
`endif

  // Even ops (MULT/DIV) are the signed variants.
  always_comb begin
    is_signed = ~op[0];
    rs_neg    = is_signed & rs_val[XLEN-1];
    rt_neg    = is_signed & rt_val[XLEN-1];
    rs_mag    = rs_neg ? -rs_val : rs_val;
    rt_mag    = rt_neg ? -rt_val : rt_val;
    op_mul    = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_DIV_EN
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
`else
    op_div    = 1'b0;
`endif
  end

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
  // Divide: {remainder, quotient} shifts left; a successful trial subtract sets the quotient bit.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
    acc_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
`ifdef MDU_DIV_EN
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};
    if (is_div)
      acc_next = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
`endif
  end

  always_comb begin
    prod   = neg_q ? -acc : acc;
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
`ifdef MDU_DIV_EN
    // A zero divisor leaves |rs| as remainder; re-signing it restores rs_val exactly.
    if (is_div) begin
      res_lo = dz ? '1 : (neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
      res_hi = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end
`endif
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      acc        <= '0;
      opb        <= '0;
      neg_q      <= 1'b0;
      done       <= 1'b0;
      illegal_op <= 1'b0;
      hi         <= '0;
      lo         <= '0;
`ifdef MDU_DIV_EN
      is_div     <= 1'b0;
      dz         <= 1'b0;
      neg_r      <= 1'b0;
`endif
    end else begin
      done       <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op_mul || op_div) begin
              acc   <= {{XLEN{1'b0}}, op_div ? rs_mag : rt_mag};
              opb   <= op_div ? rt_mag : rs_mag;
              neg_q <= rs_neg ^ rt_neg;
              cnt   <= '0;
              state <= S_CALC;
`ifdef MDU_DIV_EN
              is_div <= op_div;
              dz     <= (rt_val == '0);
              neg_r  <= rs_neg;
`endif
            end else if (op == OP_MTHI) begin
              hi   <= rs_val;
              done <= 1'b1;
            end else if (op == OP_MTLO) begin
              lo   <= rs_val;
              done <= 1'b1;
            end else begin
              illegal_op <= 1'b1;
            end
          end
        end
        S_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(XLEN - 1))
            state <= S_FIX;
        end
        S_FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: directed ops push expected HI/LO and arrival time;
// a negedge monitor pops on done/illegal_op and also checks busy run length.
`timescale 1ns/1ps
module tb_mdu_hilo;

  localparam time PER = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy, done, illegal_op;
  logic [31:0] hi, lo;

  mdu_hilo #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .illegal_op(illegal_op),
    .hi(hi), .lo(lo)
  );

  always #(PER/2) clk = ~clk;

  typedef struct {
    bit          ill;
    logic [31:0] hi;
    logic [31:0] lo;
    time         due;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;
  int unsigned busy_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done / illegal_op pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        chk("busy_len", busy_run, 33);
        busy_run = 0;
      end
      if (done || illegal_op) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {30'd0, done, illegal_op}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("kind", {31'd0, illegal_op}, {31'd0, e.ill});
          chk("pulse_excl", {31'd0, done & illegal_op}, 32'd0);
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("arrival", 32'($time / PER), 32'(e.due / PER));
        end
      end
    end
  end

  // Caller sits at a negedge; returns 1ns after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input bit ill, input bit multi,
                       input logic [31:0] eh, input logic [31:0] el);
    time t0;
    exp_t e;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk);
    t0 = $time;
    if (push) begin
      e.ill = ill; e.hi = eh; e.lo = el;
      e.due = t0 + (multi ? 33 * PER : 0) + PER / 2;
      sb.push_back(e);
      cur_hi = eh; cur_lo = el;
    end
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic run_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
    issue(o, a, b, 1, 0, 1, eh, el);
    wait_done();
  endtask

  task automatic run_ill(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b, 1, 1, 0, cur_hi, cur_lo);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_flags", {29'd0, busy, done, illegal_op}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_calc(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_calc(3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_calc(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
`ifdef MDU_DIV_EN
    run_calc(3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_calc(3'b011, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
    run_calc(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_calc(3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    run_calc(3'b010, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_calc(3'b011, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF);
`else
    run_ill(3'b010, 32'hFFFF_FFF9, 32'd2);
    run_ill(3'b011, 32'd100, 32'd0);
`endif

    issue(3'b100, 32'hDEAD_BEEF, 32'd0, 1, 0, 0, 32'hDEAD_BEEF, cur_lo);
    @(negedge clk);
    issue(3'b101, 32'h1234_5678, 32'd0, 1, 0, 0, cur_hi, 32'h1234_5678);
    @(negedge clk);
    run_ill(3'b110, 32'h5555_5555, 32'd1);
    run_ill(3'b111, 32'h5555_5555, 32'd1);
    @(negedge clk);

    // Aborted MULT: nothing pushed, any done or accepted MTLO pops an empty scoreboard.
    issue(3'b000, 32'd3, 32'd5, 0, 0, 1, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    issue(3'b101, 32'hAAAA_AAAA, 32'd0, 0, 0, 0, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    cur_hi = '0; cur_lo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_calc(3'b001, 32'd5, 32'd6, 32'd0, 32'd30);
    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
